core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
Shares one external memory port between the instruction-fetch requester (i_*) and the data requester (d_*, MEM stage) of the pipelined core. One access is in flight at a time. Requests are registered before issue. Data has fixed priority, and an optional starvation guard bounds how long fetch can wait. A pending fetch can be killed on a pipeline redirect.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
DATA_W, 64, data width; strobe width is DATA_W/8
D_BURST_MAX, 4, consecutive data grants allowed while a fetch waits (used only with the optional feature)

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset
i_req  input  1  fetch request; held high until i_ack or i_kill
i_addr  input  ADDR_W  fetch address; stable while i_req is high
i_kill  input  1  pipeline redirect; drop the current/pending fetch
i_ack  output  1  one-cycle fetch response valid
i_rdata  output  DATA_W  fetch data; valid with i_ack
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_wstrb  input  DATA_W/8  store byte enables
d_ack  output  1  one-cycle data response valid
d_rdata  output  DATA_W  load data; valid with d_ack
m_req_valid  output  1  memory request valid
m_req_ready  input  1  memory accepts the request
m_we  output  1  registered we
m_addr  output  ADDR_W  registered address
m_wdata  output  DATA_W  registered store data
m_wstrb  output  DATA_W/8  registered strobes; 0 for fetch
m_resp_valid  input  1  memory response valid
m_rdata  input  DATA_W  memory response data

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, owner=NONE, kill_pending=0, burst counter=0. All outputs are 0 (m_req_valid, m_we, m_addr, m_wdata, m_wstrb, i_ack, d_ack, i_rdata, d_rdata).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Sample requests. d_req beats i_req. A fetch is eligible only if i_req && !i_kill.
  - On a grant, latch addr/we/wdata/wstrb into the m_* registers, set owner, go to ISSUE.
  - With no grant, stay in IDLE.
- ISSUE:
  - m_req_valid=1.
  - On m_req_ready: go to WAIT and drop m_req_valid next cycle.
  - Registered m_* fields are stable for the whole ISSUE state.
- WAIT:
  - On m_resp_valid, the owner's ack is driven combinationally for exactly that cycle, with rdata passed through from m_rdata. Then go to IDLE.
  - Minimum latency: request in IDLE at cycle 0, m_req_valid at cycle 1, ack in the cycle m_resp_valid arrives (cycle 2 or later).
  - There is one idle bubble between back-to-back accesses.
- i_kill while owner=I (ISSUE or WAIT):
  - Set kill_pending.
  - The access still completes on the memory side; a request already issued is never withdrawn.
  - The response is consumed and i_ack is suppressed. kill_pending clears on return to IDLE.
- i_kill in the same cycle as i_ack: i_ack is suppressed.
- i_kill in IDLE with i_req high: no grant to fetch; d_req may still be granted.
- Simultaneous i_req and d_req in IDLE: data wins.
- m_resp_valid outside WAIT is ignored. m_req_ready outside ISSUE is ignored.
- d_ack and i_ack are never high together.

Optional Feature:
CORE_MEM_ARB_FAIRNESS_EN
- With the macro:
  - A counter increments on each data grant made while an eligible fetch was waiting.
  - When it reaches D_BURST_MAX, the next IDLE arbitration grants fetch even if d_req is high.
  - The counter clears on any fetch grant, or when no fetch is waiting.
- Without the macro: strict data priority. No counter is instantiated, and D_BURST_MAX is unused.

Decomposition:
- Shared package (def_pipeline.svh style): FSM state enum {IDLE, ISSUE, WAIT}, owner enum {NONE, I, D}, and a request struct {we, addr, wdata, wstrb}.
- One sub-module: core_mem_arb_pick (combinational grant selection plus the fairness counter). The FSM and datapath registers stay in the top.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x8000_0000, m_req_ready=1 at cycle 1, m_resp_valid at cycle 3 with m_rdata=0x00000013 -> m_addr=0x8000_0000, m_wstrb=0, i_ack=1 at cycle 3 only, i_rdata=0x13.
- Conflict: i_req and d_req (store, addr 0x1000, wdata 0xDEAD, wstrb 0x03) both rise in cycle 0 -> store issues first, d_ack on its response, fetch issues in the IDLE after, i_ack last.
- Kill in WAIT: fetch issued, i_kill pulsed before m_resp_valid -> response consumed, i_ack stays 0, FSM back in IDLE, a following d_req is served normally.
- Backpressure: m_req_ready=0 for 5 cycles during ISSUE -> m_req_valid stays 1 with m_addr/m_wdata unchanged, single handshake on ready.
- Async reset mid-WAIT: reset low between cycles -> outputs 0 immediately; after release, a stale m_resp_valid produces no ack.
- Fairness (CORE_MEM_ARB_FAIRNESS_EN, D_BURST_MAX=4): d_req held continuously with i_req high -> fetch granted after exactly 4 data acks. Without the macro -> fetch is never granted while d_req stays high.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for core_mem_arbiter: FSM state, access owner, latched memory request.
package core_mem_arbiter_pkg;

    localparam int unsigned CMA_ADDR_W = 64;
    localparam int unsigned CMA_DATA_W = 64;
    localparam int unsigned CMA_STRB_W = CMA_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic                  we;
        logic [CMA_ADDR_W-1:0] addr;
        logic [CMA_DATA_W-1:0] wdata;
        logic [CMA_STRB_W-1:0] wstrb;
    } mem_req_t;

    // Fetches are always reads with no byte enables.
    function automatic mem_req_t fetch_req(input logic [CMA_ADDR_W-1:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.addr  = addr;
        r.wdata = '0;
        r.wstrb = '0;
        return r;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bus bundle for core_mem_arbiter: fetch, data and memory-port signals.
// slave = the arbiter, master = requesters plus memory model.
interface core_mem_arbiter_if
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = CMA_ADDR_W,
    parameter int unsigned DATA_W = CMA_DATA_W
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_kill;
    logic                  i_ack;
    logic [DATA_W-1:0]     i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;
    logic                  m_req_valid;
    logic                  m_req_ready;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_resp_valid;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_req_ready, m_resp_valid, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output m_req_valid, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_req_ready, m_resp_valid, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  m_req_valid, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/core_mem_arb_pick.sv
// Grant selection for core_mem_arbiter. Data has priority; with
// CORE_MEM_ARB_FAIRNESS_EN a burst counter forces a fetch grant after D_BURST_MAX data grants.
module core_mem_arb_pick #(
    parameter int unsigned D_BURST_MAX = 4
) (
`ifdef CORE_MEM_ARB_FAIRNESS_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic arb_en,
    input  logic i_req,
    input  logic i_kill,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    logic i_elig;

    assign i_elig = i_req && !i_kill;

    if (D_BURST_MAX == 0) begin : g_burst_range
        $error("core_mem_arb_pick: D_BURST_MAX must be at least 1");
    end

`ifdef CORE_MEM_ARB_FAIRNESS_EN
    localparam int unsigned CNT_W = $clog2(D_BURST_MAX + 1);

    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] burst_d;
    logic             force_i;

    // Grant selection: a saturated burst count lets an eligible fetch jump ahead of data
    always_comb begin
        force_i = (burst_q == CNT_W'(D_BURST_MAX));
        grant_i = arb_en && i_elig && (!d_req || force_i);
        grant_d = arb_en && d_req && !grant_i;
    end

    // Burst count: data grants taken while a fetch is waiting
    always_comb begin
        burst_d = burst_q;
        if (grant_i || !i_elig) begin
            burst_d = '0;
        end else if (grant_d && !force_i) begin
            burst_d = burst_q + CNT_W'(1);
        end else begin
            burst_d = burst_q;
        end
    end

    // Burst counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    // Grant selection: strict data priority
    always_comb begin
        grant_d = arb_en && d_req;
        grant_i = arb_en && i_elig && !d_req;
    end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: one memory port shared by fetch and data, one access in flight.
// Optional CORE_MEM_ARB_FAIRNESS_EN bounds how long a fetch can be starved by data.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = CMA_ADDR_W,
    parameter int unsigned DATA_W      = CMA_DATA_W,
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    core_mem_arbiter_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e state_q;
    arb_state_e state_d;
    arb_owner_e owner_q;
    arb_owner_e owner_d;
    logic       kill_q;
    logic       kill_d;
    mem_req_t   req_q;
    mem_req_t   req_d;
    logic       arb_en;
    logic       grant_i;
    logic       grant_d;
    logic       resp_fire;
    logic       i_ack_c;
    logic       d_ack_c;

    assign arb_en = (state_q == ST_IDLE);

    core_mem_arb_pick #(
        .D_BURST_MAX (D_BURST_MAX)
    ) u_pick (
`ifdef CORE_MEM_ARB_FAIRNESS_EN
        .clock   (clock),
        .reset   (reset),
`endif
        .arb_en  (arb_en),
        .i_req   (bus.i_req),
        .i_kill  (bus.i_kill),
        .d_req   (bus.d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // State, owner, kill flag and latched request registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            kill_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_i || grant_d) state_d = ST_ISSUE;
                else                    state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (bus.m_req_ready) state_d = ST_WAIT;
                else                 state_d = ST_ISSUE;
            end
            ST_WAIT: begin
                if (bus.m_resp_valid) state_d = ST_IDLE;
                else                  state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and owner tracking; a killed fetch still runs to completion
    always_comb begin
        owner_d = owner_q;
        kill_d  = kill_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    owner_d     = OWN_D;
                    req_d.we    = bus.d_we;
                    req_d.addr  = CMA_ADDR_W'(bus.d_addr);
                    req_d.wdata = CMA_DATA_W'(bus.d_wdata);
                    req_d.wstrb = CMA_STRB_W'(bus.d_wstrb);
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    req_d   = fetch_req(CMA_ADDR_W'(bus.i_addr));
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            ST_ISSUE: begin
                if (owner_q == OWN_I && bus.i_kill) kill_d = 1'b1;
                else                                kill_d = kill_q;
            end
            ST_WAIT: begin
                if (bus.m_resp_valid) begin
                    owner_d = OWN_NONE;
                    kill_d  = 1'b0;
                end else if (owner_q == OWN_I && bus.i_kill) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // Outputs: memory fields straight from registers, acks in the response cycle only
    always_comb begin
        resp_fire       = (state_q == ST_WAIT) && bus.m_resp_valid;
        d_ack_c         = resp_fire && (owner_q == OWN_D);
        i_ack_c         = resp_fire && (owner_q == OWN_I) && !kill_q && !bus.i_kill;
        bus.m_req_valid = (state_q == ST_ISSUE);
        bus.m_we        = req_q.we;
        bus.m_addr      = ADDR_W'(req_q.addr);
        bus.m_wdata     = DATA_W'(req_q.wdata);
        bus.m_wstrb     = STRB_W'(req_q.wstrb);
        bus.i_ack       = i_ack_c;
        bus.d_ack       = d_ack_c;
        if (i_ack_c) bus.i_rdata = bus.m_rdata;
        else         bus.i_rdata = '0;
        if (d_ack_c) bus.d_rdata = bus.m_rdata;
        else         bus.d_rdata = '0;
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus randomized
// traffic, both compared every cycle against a transaction-level model.
module tb_core_mem_arbiter;

    localparam int unsigned TB_BURST = 4;
`ifdef CORE_MEM_ARB_FAIRNESS_EN
    localparam int BURST_LIMIT = TB_BURST;
`else
    localparam int BURST_LIMIT = 32'd1 << 30;
`endif

    logic clock;
    logic reset;

    core_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    core_mem_arbiter #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .D_BURST_MAX (TB_BURST)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // transaction-level model: at most one access outstanding
    bit          md_have, md_acc, md_is_i, md_killed, md_we;
    logic [63:0] md_addr, md_wdata;
    logic [7:0]  md_wstrb;
    int          streak;
    logic        exp_valid, exp_i_ack, exp_d_ack;
    bit          i_pending, d_pending;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        md_have = 0; md_acc = 0; md_is_i = 0; md_killed = 0; md_we = 0;
        md_addr = '0; md_wdata = '0; md_wstrb = '0; streak = 0;
    endtask

    // advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit elig, take_i, take_d;
        elig = bus.i_req && !bus.i_kill;
        if (!md_have) begin
            take_i = elig && (!bus.d_req || streak >= BURST_LIMIT);
            take_d = bus.d_req && !take_i;
            if (take_d) begin
                md_have = 1; md_acc = 0; md_is_i = 0; md_killed = 0;
                md_we = bus.d_we; md_addr = bus.d_addr; md_wdata = bus.d_wdata; md_wstrb = bus.d_wstrb;
            end else if (take_i) begin
                md_have = 1; md_acc = 0; md_is_i = 1; md_killed = 0;
                md_we = 0; md_addr = bus.i_addr; md_wdata = '0; md_wstrb = '0;
            end
            if (take_i || !elig) streak = 0;
            else if (take_d) streak++;
        end else begin
            if (!elig) streak = 0;
            if (md_is_i && bus.i_kill) md_killed = 1;
            if (!md_acc) begin
                if (bus.m_req_ready) md_acc = 1;
            end else if (bus.m_resp_valid) begin
                md_have = 0;
            end
        end
    endtask

    task automatic compare();
        exp_valid = md_have && !md_acc;
        exp_d_ack = md_have && md_acc && !md_is_i && bus.m_resp_valid;
        exp_i_ack = md_have && md_acc && md_is_i && bus.m_resp_valid && !md_killed && !bus.i_kill;
        chk1("m_req_valid", bus.m_req_valid, exp_valid);
        chk1("i_ack", bus.i_ack, exp_i_ack);
        chk1("d_ack", bus.d_ack, exp_d_ack);
        chk1("ack_exclusive", bus.i_ack && bus.d_ack, 1'b0);
        if (exp_valid) begin
            chk("m_addr", bus.m_addr, md_addr);
            chk1("m_we", bus.m_we, md_we);
            chk("m_wstrb", 64'(bus.m_wstrb), 64'(md_wstrb));
            if (!md_is_i) chk("m_wdata", bus.m_wdata, md_wdata);
        end
        if (exp_i_ack) chk("i_rdata", bus.i_rdata, bus.m_rdata);
        if (exp_d_ack) chk("d_rdata", bus.d_rdata, bus.m_rdata);
    endtask

    task automatic tick_check();
        @(negedge clock);
        compare();
    endtask

    task automatic tick_adv();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic cyc();
        tick_check();
        tick_adv();
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = '0; bus.i_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.m_req_ready = 0; bus.m_resp_valid = 0; bus.m_rdata = '0;
    endtask

    task automatic drive_random();
        if (!i_pending && $urandom_range(3) == 0) begin
            i_pending = 1;
            bus.i_addr = {$urandom, $urandom};
        end
        bus.i_req  = i_pending;
        bus.i_kill = ($urandom_range(24) == 0);
        if (!d_pending && $urandom_range(2) == 0) begin
            d_pending   = 1;
            bus.d_we    = 1'($urandom_range(1));
            bus.d_addr  = {$urandom, $urandom};
            bus.d_wdata = {$urandom, $urandom};
            bus.d_wstrb = 8'($urandom);
        end
        bus.d_req        = d_pending;
        bus.m_req_ready  = 1'($urandom_range(1));
        bus.m_resp_valid = ($urandom_range(2) == 0);
        bus.m_rdata      = {$urandom, $urandom};
    endtask

    initial begin
        int  dcount;
        bit  i_seen;
        logic [63:0] rd;

        model_reset();
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk1("rst_m_req_valid", bus.m_req_valid, 1'b0);
        chk1("rst_m_we", bus.m_we, 1'b0);
        chk("rst_m_addr", bus.m_addr, 64'd0);
        chk("rst_m_wdata", bus.m_wdata, 64'd0);
        chk("rst_m_wstrb", 64'(bus.m_wstrb), 64'd0);
        chk1("rst_i_ack", bus.i_ack, 1'b0);
        chk1("rst_d_ack", bus.d_ack, 1'b0);
        chk("rst_i_rdata", bus.i_rdata, 64'd0);
        chk("rst_d_rdata", bus.d_rdata, 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // lone fetch
        bus.i_req = 1; bus.i_addr = 64'h8000_0000;
        cyc();
        bus.m_req_ready = 1;
        tick_check();
        chk1("lone_model_valid", exp_valid, 1'b1);
        chk1("lone_valid_c1", bus.m_req_valid, 1'b1);
        chk("lone_m_addr", bus.m_addr, 64'h8000_0000);
        chk("lone_m_wstrb", 64'(bus.m_wstrb), 64'd0);
        tick_adv();
        bus.m_req_ready = 0;
        tick_check();
        chk1("lone_no_ack_c2", bus.i_ack, 1'b0);
        tick_adv();
        bus.m_resp_valid = 1; bus.m_rdata = 64'h13;
        tick_check();
        chk1("lone_model_ack", exp_i_ack, 1'b1);
        chk1("lone_i_ack_c3", bus.i_ack, 1'b1);
        chk("lone_i_rdata", bus.i_rdata, 64'h13);
        tick_adv();
        idle_inputs();
        tick_check();
        chk1("lone_ack_one_cycle", bus.i_ack, 1'b0);
        tick_adv();

        // conflict: store beats fetch, fetch follows after one idle cycle
        bus.i_req = 1; bus.i_addr = 64'h8000_0040;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h1000; bus.d_wdata = 64'hDEAD; bus.d_wstrb = 8'h03;
        bus.m_req_ready = 1;
        cyc();
        tick_check();
        chk1("cfl_store_we", bus.m_we, 1'b1);
        chk("cfl_store_addr", bus.m_addr, 64'h1000);
        chk("cfl_store_wdata", bus.m_wdata, 64'hDEAD);
        chk("cfl_store_wstrb", 64'(bus.m_wstrb), 64'h03);
        tick_adv();
        bus.m_resp_valid = 1;
        tick_check();
        chk1("cfl_d_ack", bus.d_ack, 1'b1);
        chk1("cfl_no_i_ack", bus.i_ack, 1'b0);
        tick_adv();
        bus.d_req = 0; bus.m_resp_valid = 0;
        tick_check();
        chk1("cfl_bubble", bus.m_req_valid, 1'b0);
        tick_adv();
        tick_check();
        chk("cfl_fetch_addr", bus.m_addr, 64'h8000_0040);
        tick_adv();
        bus.m_resp_valid = 1; bus.m_rdata = 64'h55;
        tick_check();
        chk1("cfl_i_ack", bus.i_ack, 1'b1);
        tick_adv();
        idle_inputs();
        cyc();

        // kill in WAIT, then a load is served normally
        bus.i_req = 1; bus.i_addr = 64'h8000_0100; bus.m_req_ready = 1;
        cyc();
        cyc();
        bus.i_kill = 1;
        cyc();
        bus.i_kill = 0; bus.i_req = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h2000; bus.m_resp_valid = 1;
        tick_check();
        chk1("kill_no_i_ack", bus.i_ack, 1'b0);
        chk1("kill_no_d_ack", bus.d_ack, 1'b0);
        tick_adv();
        bus.m_resp_valid = 0;
        cyc();
        tick_check();
        chk("kill_load_addr", bus.m_addr, 64'h2000);
        tick_adv();
        bus.m_resp_valid = 1; bus.m_rdata = 64'h1234_5678_9ABC_DEF0;
        tick_check();
        chk1("kill_d_ack", bus.d_ack, 1'b1);
        chk("kill_d_rdata", bus.d_rdata, 64'h1234_5678_9ABC_DEF0);
        tick_adv();
        idle_inputs();
        cyc();

        // backpressure: five cycles of not-ready in ISSUE
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h3000; bus.d_wdata = 64'hCAFE_F00D; bus.d_wstrb = 8'hF0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            tick_check();
            chk1("bp_valid_held", bus.m_req_valid, 1'b1);
            chk("bp_addr_stable", bus.m_addr, 64'h3000);
            chk("bp_wdata_stable", bus.m_wdata, 64'hCAFE_F00D);
            tick_adv();
        end
        bus.m_req_ready = 1;
        cyc();
        tick_check();
        chk1("bp_single_handshake", bus.m_req_valid, 1'b0);
        tick_adv();
        bus.m_resp_valid = 1;
        cyc();
        idle_inputs();
        cyc();

        // asynchronous reset while a fetch waits for its response
        bus.i_req = 1; bus.i_addr = 64'hC0DE_0000; bus.m_req_ready = 1;
        cyc();
        cyc();
        bus.m_req_ready = 0; bus.m_resp_valid = 1; bus.m_rdata = 64'h77;
        #2 reset = 1'b0;
        #1;
        chk1("arst_i_ack", bus.i_ack, 1'b0);
        chk("arst_i_rdata", bus.i_rdata, 64'd0);
        chk("arst_m_addr", bus.m_addr, 64'd0);
        chk1("arst_m_req_valid", bus.m_req_valid, 1'b0);
        model_reset();
        bus.i_req = 0;
        @(posedge clock);
        #1 reset = 1'b1;
        tick_check();
        chk1("arst_stale_i_ack", bus.i_ack, 1'b0);
        chk1("arst_stale_d_ack", bus.d_ack, 1'b0);
        tick_adv();
        bus.m_resp_valid = 0;
        cyc();

        // starvation: data held continuously against a waiting fetch
        dcount = 0;
        i_seen = 0;
        bus.i_req = 1; bus.i_addr = 64'h9000;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h4000;
        bus.m_req_ready = 1; bus.m_resp_valid = 1;
        for (int c = 0; c < 40; c++) begin
            rd = {$urandom, $urandom};
            bus.m_rdata = rd;
            tick_check();
            if (bus.d_ack && !i_seen) dcount++;
            if (bus.i_ack) i_seen = 1;
            tick_adv();
            if (exp_i_ack) bus.i_req = 0;
        end
`ifdef CORE_MEM_ARB_FAIRNESS_EN
        chk("fair_d_acks_before_fetch", 64'(dcount), 64'd4);
        chk1("fair_fetch_served", i_seen, 1'b1);
`else
        chk1("strict_fetch_starved", i_seen, 1'b0);
        chk1("strict_data_served", dcount >= 10, 1'b1);
`endif

        // randomized traffic, requests held per protocol until acked or killed
        i_pending = bus.i_req;
        d_pending = 1;
        for (int c = 0; c < 1500; c++) begin
            drive_random();
            cyc();
            if (exp_i_ack || bus.i_kill) i_pending = 0;
            if (exp_d_ack) d_pending = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
